// File: rtl/rgst_drain_if.sv
// Producer/consumer bundle for rgst_drain: push strobe and data in, valid/ready head word out,
// plus occupancy and overrun status.
interface rgst_drain_if #(
  parameter int dw    = 'h10,
  parameter int depth = 4
);
  localparam int cw = $clog2(depth) + 1;

  logic          clr;
  logic          ld;
  logic [dw-1:0] d;
  logic          rdy;
  logic          vld;
  logic [dw-1:0] q;
  logic [cw-1:0] cnt;
  logic          full;
  logic          ovf;

  modport master (
    output clr, ld, d, rdy,
    input  vld, q, cnt, full, ovf
  );

  modport slave (
    input  clr, ld, d, rdy,
    output vld, q, cnt, full, ovf
  );
endinterface

// File: rtl/rgst_drain.sv
// Circular buffer between a non-stallable ld/d producer and a valid/ready consumer.
// Words that arrive while full with no pop are dropped and latched into a sticky ovf flag.
module rgst_drain #(
  parameter int            dw      = 'h10,
  parameter int            depth   = 4,
  parameter logic [dw-1:0] clr_val = '0
) (
  input  logic         clk,
  input  logic         rst,
  rgst_drain_if.slave  bus
);
  localparam int aw = $clog2(depth);
  localparam int cw = aw + 1;
  localparam logic [cw-1:0] cnt_full = cw'(depth);

  logic [dw-1:0] mem_q [depth];
  logic [dw-1:0] mem_d [depth];
  logic [aw-1:0] rd_ptr_q, rd_ptr_d;
  logic [aw-1:0] wr_ptr_q, wr_ptr_d;
  logic [cw-1:0] cnt_q, cnt_d;
  logic          ovf_q, ovf_d;

  logic vld;
  logic full;
  logic pop;
  logic push;

  assign vld  = (cnt_q != '0);
  assign full = (cnt_q == cnt_full);
  assign pop  = vld & bus.rdy;
  // A pop in the same cycle frees the slot the incoming word needs, even when full.
  assign push = bus.ld & (~full | pop);

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;

    if (bus.clr) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      cnt_d    = '0;
      ovf_d    = 1'b0;
    end else begin
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      if (push) begin
        mem_d[wr_ptr_q] = bus.d;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
      if (bus.ld & full & ~pop) begin
        ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < depth; i++) begin
        mem_q[i] <= '0;
      end
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
    end
  end

  assign bus.vld  = vld;
  assign bus.q    = vld ? mem_q[rd_ptr_q] : clr_val;
  assign bus.cnt  = cnt_q;
  assign bus.full = full;
  assign bus.ovf  = ovf_q;
endmodule

// File: tb/tb_rgst_drain.sv
// Directed bench for rgst_drain: reset, latency, overrun, full push+pop, flush priority,
// pointer wrap while streaming, and asynchronous reset mid-stream.
module tb_rgst_drain;
  logic clk;
  logic rst;
  int   checks;
  int   failures;

  rgst_drain_if #(.dw(16), .depth(4)) bus ();

  rgst_drain #(
    .dw      (16),
    .depth   (4),
    .clr_val (16'h0000)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_status(input string tag, input logic v, input logic [15:0] qv,
                              input logic [2:0] c, input logic f, input logic o);
    check({tag, ".vld"},  {31'b0, bus.vld},  {31'b0, v});
    check({tag, ".q"},    {16'b0, bus.q},    {16'b0, qv});
    check({tag, ".cnt"},  {29'b0, bus.cnt},  {29'b0, c});
    check({tag, ".full"}, {31'b0, bus.full}, {31'b0, f});
    check({tag, ".ovf"},  {31'b0, bus.ovf},  {31'b0, o});
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    bus.clr  = 1'b0;
    bus.ld   = 1'b0;
    bus.d    = 16'h0000;
    bus.rdy  = 1'b0;

    // 1: reset state before any clock edge
    #1;
    check_status("reset", 1'b0, 16'h0000, 3'd0, 1'b0, 1'b0);
    #2;
    rst = 1'b0;

    // 2: single word latency
    bus.ld  = 1'b1;
    bus.d   = 16'h1234;
    bus.rdy = 1'b1;
    tick();
    check_status("single_push", 1'b1, 16'h1234, 3'd1, 1'b0, 1'b0);
    bus.ld = 1'b0;
    tick();
    check_status("single_pop", 1'b0, 16'h0000, 3'd0, 1'b0, 1'b0);

    // 3: overrun while stalled
    bus.rdy = 1'b0;
    bus.ld  = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      bus.d = 16'hA000 + 16'(i);
      tick();
      if (i == 4) check_status("fill4", 1'b1, 16'hA001, 3'd4, 1'b1, 1'b0);
    end
    check_status("ovf5", 1'b1, 16'hA001, 3'd4, 1'b1, 1'b1);
    bus.ld  = 1'b0;
    bus.rdy = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      check("drain_a.q", {16'b0, bus.q}, 32'h0000A000 + i);
      tick();
    end
    check_status("drain_a_done", 1'b0, 16'h0000, 3'd0, 1'b0, 1'b1);

    // 4: full buffer, push and pop together
    bus.clr = 1'b1;
    tick();
    bus.clr = 1'b0;
    check_status("clr_ovf", 1'b0, 16'h0000, 3'd0, 1'b0, 1'b0);
    bus.rdy = 1'b0;
    bus.ld  = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      bus.d = 16'hB000 + 16'(i);
      tick();
    end
    check_status("fill_b", 1'b1, 16'hB001, 3'd4, 1'b1, 1'b0);
    bus.d   = 16'hB005;
    bus.rdy = 1'b1;
    tick();
    check_status("full_pushpop", 1'b1, 16'hB002, 3'd4, 1'b1, 1'b0);
    bus.ld = 1'b0;
    for (int i = 2; i <= 5; i++) begin
      check("drain_b.q", {16'b0, bus.q}, 32'h0000B000 + i);
      tick();
    end
    check_status("drain_b_done", 1'b0, 16'h0000, 3'd0, 1'b0, 1'b0);

    // 5: flush beats a same-cycle ld
    bus.rdy = 1'b0;
    bus.ld  = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      bus.d = 16'hC000 + 16'(i);
      tick();
    end
    bus.ld  = 1'b0;
    bus.rdy = 1'b1;
    tick();
    check_status("pre_clr", 1'b1, 16'hC002, 3'd3, 1'b0, 1'b1);
    bus.rdy = 1'b0;
    bus.clr = 1'b1;
    bus.ld  = 1'b1;
    bus.d   = 16'hC006;
    tick();
    bus.clr = 1'b0;
    bus.ld  = 1'b0;
    check_status("clr_with_ld", 1'b0, 16'h0000, 3'd0, 1'b0, 1'b0);

    // 6: streaming through pointer wrap, then async reset mid-stream
    bus.rdy = 1'b1;
    bus.ld  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bus.d = 16'(i);
      tick();
      check("stream.q",   {16'b0, bus.q},   32'(i));
      check("stream.cnt", {29'b0, bus.cnt}, 32'd1);
    end
    bus.d = 16'h00AA;
    #1;
    rst = 1'b1;
    #1;
    check_status("async_rst", 1'b0, 16'h0000, 3'd0, 1'b0, 1'b0);
    tick();
    check_status("rst_held", 1'b0, 16'h0000, 3'd0, 1'b0, 1'b0);
    rst    = 1'b0;
    bus.ld = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
